multicycle_controller: RTL and testbench

Moore-style control FSM that sequences the multicycle MIPS-subset datapath: fetch, decode, execute, memory and write-back across 3-5 clocks per instruction. Consumes `Op`, `Function` and `Zero` from the datapath and drives every datapath select and write strobe. Supports lw, sw, beq, addi and R-type add/sub/and/or/xor/nor/slt. Traps undecodable instructions in a sticky illegal state.

---
 rtl/multicycle_controller.sv | 208 ++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle MIPS-subset datapath (lw, sw, beq, addi, R-type).
// Optional feature: define MC_BNE_EN to decode bne (Op 000101) as a branch on ~Zero.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic [5:0] Function,
  input  logic       Zero,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemToReg,
  output logic       IRWrite,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       PCSel,
  output logic [1:0] PCSource,
  output logic [1:0] ALUSrcB,
  output logic [3:0] ALUCtrl,
  output logic [3:0] state,
  output logic       illegal,
  output logic       instr_done
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_ILLEGAL = 4'd15
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_XOR = 4'b0010;
  localparam logic [3:0] ALU_NOR = 4'b0011;
  localparam logic [3:0] ALU_ADD = 4'b0110;
  localparam logic [3:0] ALU_SUB = 4'b1110;
  localparam logic [3:0] ALU_SLT = 4'b1111;

  state_e     state_q, state_d;
  logic       fn_legal;
  logic [3:0] fn_alu;
  logic       op_branch;
  logic       branch_take;

  // R-type function decode; the IR is stable after FETCH, so EXEC and RTYPEWB both read it.
  always_comb begin
    fn_legal = 1'b1;
    fn_alu   = ALU_ADD;
    case (Function)
      6'b100000: fn_alu = ALU_ADD;
      6'b100010: fn_alu = ALU_SUB;
      6'b100100: fn_alu = ALU_AND;
      6'b100101: fn_alu = ALU_OR;
      6'b100110: fn_alu = ALU_XOR;
      6'b100111: fn_alu = ALU_NOR;
      6'b101010: fn_alu = ALU_SLT;
      default:   fn_legal = 1'b0;
    endcase
  end

`ifdef MC_BNE_EN
  assign op_branch   = (Op == OP_BEQ) || (Op == OP_BNE);
  assign branch_take = (Op == OP_BNE) ? ~Zero : Zero;
`else
  assign op_branch   = (Op == OP_BEQ);
  assign branch_take = Zero;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // instr_done marks the final cycle of every retired instruction; a reset cycle
  // suppresses every strobe so an abandoned instruction leaves no side effects.
  always_comb begin
    state_d    = state_q;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    MemToReg   = 1'b0;
    IRWrite    = 1'b0;
    ALUSrcA    = 1'b0;
    RegWrite   = 1'b0;
    RegDst     = 1'b0;
    PCSel      = 1'b0;
    PCSource   = 2'b00;
    ALUSrcB    = 2'b00;
    ALUCtrl    = ALU_ADD;
    illegal    = 1'b0;
    instr_done = 1'b0;

    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        IRWrite = 1'b1;
        PCSel   = 1'b1;
        ALUSrcB = 2'b01;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        if ((Op == OP_LW) || (Op == OP_SW)) state_d = S_MEMADR;
        else if (Op == OP_RTYPE)            state_d = fn_legal ? S_EXEC : S_ILLEGAL;
        else if (op_branch)                 state_d = S_BRANCH;
        else if (Op == OP_ADDI)             state_d = S_ADDIEX;
        else                                state_d = S_ILLEGAL;
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        RegWrite   = 1'b1;
        MemToReg   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        IorD       = 1'b1;
        MemWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUCtrl = fn_alu;
        state_d = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        RegWrite   = 1'b1;
        RegDst     = 1'b1;
        ALUCtrl    = fn_alu;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUCtrl    = ALU_SUB;
        PCSource   = 2'b01;
        PCSel      = branch_take;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_ILLEGAL: begin
        illegal = 1'b1;
        state_d = S_ILLEGAL;
      end
      default: begin
        illegal = 1'b1;
        state_d = S_ILLEGAL;
      end
    endcase

    if (reset) begin
      IorD       = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      MemToReg   = 1'b0;
      IRWrite    = 1'b0;
      ALUSrcA    = 1'b0;
      RegWrite   = 1'b0;
      RegDst     = 1'b0;
      PCSel      = 1'b0;
      PCSource   = 2'b00;
      ALUSrcB    = 2'b00;
      ALUCtrl    = 4'b0000;
      illegal    = 1'b0;
      instr_done = 1'b0;
    end
  end

  assign state = reset ? 4'd0 : state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller: an instruction-level model predicts every
// cycle's control word into a queue; a negedge monitor pops and compares.
module tb_multicycle_controller;

  localparam int W = 23;

  localparam int CL_LW   = 0;
  localparam int CL_SW   = 1;
  localparam int CL_R    = 2;
  localparam int CL_BEQ  = 3;
  localparam int CL_BNE  = 4;
  localparam int CL_ADDI = 5;
  localparam int CL_ILL  = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] Op = 6'd0;
  logic [5:0] Function = 6'd0;
  logic       Zero = 1'b0;
  logic       IorD, MemRead, MemWrite, MemToReg, IRWrite, ALUSrcA;
  logic       RegWrite, RegDst, PCSel, illegal, instr_done;
  logic [1:0] PCSource, ALUSrcB;
  logic [3:0] ALUCtrl, state;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] act_vec;
  logic         mon_en = 1'b0;
  int           n_checks = 0;
  int           n_pass = 0;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .Op(Op), .Function(Function), .Zero(Zero),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .MemToReg(MemToReg),
    .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite), .RegDst(RegDst),
    .PCSel(PCSel), .PCSource(PCSource), .ALUSrcB(ALUSrcB), .ALUCtrl(ALUCtrl),
    .state(state), .illegal(illegal), .instr_done(instr_done)
  );

  always #5 clk = ~clk;

  assign act_vec = {state, illegal, instr_done, IorD, MemRead, MemWrite, MemToReg,
                    IRWrite, ALUSrcA, RegWrite, RegDst, PCSel, PCSource, ALUSrcB, ALUCtrl};

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] cw(input int st, input bit ill, input bit done,
      input bit iord, input bit mrd, input bit mwr, input bit m2r, input bit irw,
      input bit asa, input bit rw, input bit rdst, input bit pcs, input int pcsrc,
      input int asb, input int alu);
    logic [3:0] s4, a4;
    logic [1:0] p2, b2;
    s4 = st[3:0]; p2 = pcsrc[1:0]; b2 = asb[1:0]; a4 = alu[3:0];
    return {s4, ill, done, iord, mrd, mwr, m2r, irw, asa, rw, rdst, pcs, p2, b2, a4};
  endfunction

  function automatic int alu_of(input logic [5:0] fn);
    case (fn)
      6'd32:   return 6;
      6'd34:   return 14;
      6'd36:   return 0;
      6'd37:   return 1;
      6'd38:   return 2;
      6'd39:   return 3;
      6'd42:   return 15;
      default: return -1;
    endcase
  endfunction

  function automatic int class_of(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'd35:   return CL_LW;
      6'd43:   return CL_SW;
      6'd0:    return (alu_of(fn) >= 0) ? CL_R : CL_ILL;
      6'd4:    return CL_BEQ;
      6'd8:    return CL_ADDI;
`ifdef MC_BNE_EN
      6'd5:    return CL_BNE;
`endif
      default: return CL_ILL;
    endcase
  endfunction

  function automatic int len_of(input int c);
    case (c)
      CL_LW:          return 5;
      CL_SW, CL_R:    return 4;
      CL_ADDI:        return 4;
      CL_BEQ, CL_BNE: return 3;
      default:        return 2;
    endcase
  endfunction

  // Control word expected in cycle k of an instruction (k=0 is the fetch cycle).
  function automatic logic [W-1:0] step_vec(input int c, input int k,
      input logic [5:0] fn, input bit z);
    int alu;
    alu = alu_of(fn);
    if (k == 0) return cw(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 1, 0, 1, 6);
    if (k == 1) return cw(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 6);
    case (c)
      CL_LW: begin
        if (k == 2) return cw(2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2, 6);
        if (k == 3) return cw(3, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6);
        return cw(4, 0, 1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 6);
      end
      CL_SW: begin
        if (k == 2) return cw(2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2, 6);
        return cw(5, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 6);
      end
      CL_R: begin
        if (k == 2) return cw(6, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, alu);
        return cw(7, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, alu);
      end
      CL_BEQ: return cw(8, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, z, 1, 0, 14);
      CL_BNE: return cw(8, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, !z, 1, 0, 14);
      CL_ADDI: begin
        if (k == 2) return cw(9, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2, 6);
        return cw(10, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 6);
      end
      default: return cw(15, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6);
    endcase
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL underflow t=%0t: got state=%0d word=%h, required nothing pending",
                 $time, state, act_vec);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (act_vec === e) n_pass++;
        else $display("FAIL ctrl_word t=%0t: got state=%0d word=%h, required state=%0d word=%h",
                      $time, state, act_vec, e[W-1 -: 4], e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('0);
      @(posedge clk); #1;
    end
    reset = 1'b0;
  endtask

  // abort_at >= 0 asserts reset after that many cycles of the instruction.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input bit z,
                           input int abort_at, input int ill_hold);
    int c, n;
    bit aborted;
    c = class_of(op, fn);
    n = (c == CL_ILL) ? 2 + ill_hold : len_of(c);
    aborted = (abort_at >= 0) && (abort_at < n);
    if (aborted) n = abort_at;
    Op = op; Function = fn; Zero = z;
    for (int k = 0; k < n; k++) exp_q.push_back(step_vec(c, k, fn, z));
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      if (c == CL_ILL && k >= 1) begin
        Op = 6'($urandom_range(0, 63));
        Function = 6'($urandom_range(0, 63));
        Zero = 1'($urandom_range(0, 1));
      end
    end
    if (c == CL_ILL || aborted) do_reset(aborted ? 1 : $urandom_range(1, 2));
  endtask

  localparam logic [5:0] LEGAL_FN [7] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd38, 6'd39, 6'd42};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required bench completion");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $finish;
  end

  initial begin
    @(posedge clk); #1;
    mon_en = 1'b1;
    do_reset(3);

    run_instr(6'b100011, 6'd0, 1'b0, -1, 0);        // lw
    run_instr(6'b000000, 6'b100010, 1'b0, -1, 0);   // sub
    run_instr(6'b000000, 6'b101010, 1'b1, -1, 0);   // slt
    run_instr(6'b000100, 6'd7, 1'b1, -1, 0);        // beq taken
    run_instr(6'b000100, 6'd7, 1'b0, -1, 0);        // beq not taken
    run_instr(6'b001000, 6'd3, 1'b0, -1, 0);        // addi
    run_instr(6'b101011, 6'd0, 1'b0, -1, 0);        // sw
    run_instr(6'b111111, 6'd0, 1'b0, -1, 20);       // undefined op
    run_instr(6'b000101, 6'd0, 1'b1, -1, 20);       // bne
    run_instr(6'b000101, 6'd0, 1'b0, -1, 20);
    run_instr(6'b000000, 6'b000001, 1'b0, -1, 5);   // bad function
    run_instr(6'b101011, 6'd0, 1'b0, 3, 0);         // reset during MEMWR

    for (int i = 0; i < 250; i++) begin
      logic [5:0] op, fn;
      int sel, ab;
      fn = 6'($urandom_range(0, 63));
      sel = $urandom_range(0, 9);
      case (sel)
        0: op = 6'd35;
        1: op = 6'd43;
        2, 3: begin op = 6'd0; fn = LEGAL_FN[$urandom_range(0, 6)]; end
        4: op = 6'd0;
        5: op = 6'd4;
        6: op = 6'd8;
        7: op = 6'd5;
        default: op = 6'($urandom_range(0, 63));
      endcase
      ab = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 4) : -1;
      run_instr(op, fn, 1'($urandom_range(0, 1)), ab, $urandom_range(1, 6));
    end

    mon_en = 1'b0;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending words, required 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
